// File: rtl/song_reader_if.sv
// song_reader <-> note_player handshake bundle.
// The master presents a note/duration pair with a one-cycle load pulse.
interface song_reader_if;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic       load_new_note;
  logic       note_done;

  modport master (
    output note_to_load,
    output duration_to_load,
    output load_new_note,
    input  note_done
  );

  modport slave (
    input  note_to_load,
    input  duration_to_load,
    input  load_new_note,
    output note_done
  );
endinterface

// File: rtl/song_reader.sv
// Song ROM sequencer: walks one song's entries and feeds
// note_player one {note, duration} pair at a time.
module song_reader #(
  parameter int SONG_ADDR_W = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic [1:0]             song,
  input  logic                   new_song,
  output logic [SONG_ADDR_W+1:0] rom_addr,
  input  logic [11:0]            rom_data,
  output logic                   song_done,
  output logic [SONG_ADDR_W-1:0] note_index,
  song_reader_if.master          nif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    LOAD,
    WAIT_CLEAR,
    WAIT_DONE,
    DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_song;
  logic [SONG_ADDR_W-1:0] r_idx;
  logic [5:0]             r_note;
  logic [5:0]             r_dur;
  logic                   w_inc;
  logic                   w_last;
  logic                   w_dur_zero;

  assign w_last     = (r_idx == '1);
  assign w_dur_zero = (rom_data[5:0] == 6'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    if (new_song) begin
      w_next = FETCH;
    end else begin
      unique case (r_state)
        IDLE:       w_next = IDLE;
        FETCH:      w_next = WAIT_ROM;
        WAIT_ROM: begin
          if (w_dur_zero) w_next = DONE;
          else if (play)  w_next = LOAD;
        end
        LOAD:       w_next = WAIT_CLEAR;
        // done_with_note is still high from the previous note here
        WAIT_CLEAR: if (!nif.note_done) w_next = WAIT_DONE;
        WAIT_DONE: begin
          if (nif.note_done) begin
            if (w_last) begin
              w_next = DONE;
            end else begin
              w_next = FETCH;
              w_inc  = 1'b1;
            end
          end
        end
        DONE:       w_next = DONE;
        default:    w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_song <= 2'd0;
      r_idx  <= '0;
      r_note <= 6'd0;
      r_dur  <= 6'd0;
    end else begin
      if (new_song) begin
        r_song <= song;
        r_idx  <= '0;
      end else if (w_inc) begin
        r_idx  <= r_idx + 1'b1;
      end
      if (r_state == WAIT_ROM) begin
        r_note <= rom_data[11:6];
        r_dur  <= rom_data[5:0];
      end
    end
  end

  assign rom_addr             = {r_song, r_idx};
  assign note_index           = r_idx;
  assign song_done            = (r_state == DONE);
  assign nif.load_new_note    = (r_state == LOAD);
  assign nif.note_to_load     = r_note;
  assign nif.duration_to_load = r_dur;

endmodule

// File: doc/song_reader.md
# song_reader

Sequencer that feeds the note player. It walks one song's entries in the song ROM and presents each {note, duration} pair with a one-cycle load pulse. It waits for the player to finish each note before fetching the next, and flags the end of the song. It sits between the top-level play/song controls and note_player, on the other side of note_player's load_new_note / done_with_note handshake.

## Interface
- SONG_ADDR_W, 7, bits of note index per song (2^SONG_ADDR_W entries per song)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; forces reset state immediately
- play  in  1  1 = may issue new notes; 0 = hold before the next load
- song  in  2  song select; sampled only when new_song = 1
- new_song  in  1  single-cycle request to (re)start `song` from entry 0
- rom_addr  out  SONG_ADDR_W+2  {song_reg, note_index} to the song ROM
- rom_data  in  12  {note[11:6], duration[5:0]} from the song ROM; valid 1 cycle after rom_addr
- note_to_load  out  6  captured note, held until the next capture
- duration_to_load  out  6  captured duration, held until the next capture
- load_new_note  out  1  one-cycle pulse; note/duration are valid in the same cycle
- note_done  in  1  done_with_note from the player (level)
- song_done  out  1  level; high from end of song until new_song or reset
- note_index  out  SONG_ADDR_W  index of the current entry

## Operation
- States: IDLE, FETCH, WAIT_ROM, LOAD, WAIT_CLEAR, WAIT_DONE, DONE. The state register is the only state-holding element besides the data registers.
- Reset (reset = 0): state = IDLE. song_reg, note_index, note_to_load and duration_to_load are 0. load_new_note = 0 and song_done = 0.
- new_song = 1 has top priority in any state. On that edge: song_reg <= song, note_index <= 0, song_done <= 0, state <= FETCH. Any in-progress load is abandoned, and load_new_note is 0 in the following cycle.
- IDLE: stays in IDLE until new_song.
- FETCH: lasts 1 cycle with rom_addr stable, then goes to WAIT_ROM.
- WAIT_ROM: note_to_load and duration_to_load capture rom_data on every edge spent in this state.
  - If duration = 0, the entry is an end-of-song marker: go to DONE and do not load.
  - Otherwise, if play = 1, go to LOAD.
  - Otherwise stay in WAIT_ROM. The address is unchanged, so the data stays valid.
- LOAD: load_new_note = 1 for exactly this cycle, then go to WAIT_CLEAR.
- WAIT_CLEAR: ignores the player's stale note_done from the previous note. Moves to WAIT_DONE on the first edge with note_done = 0.
- WAIT_DONE: on note_done = 1:
  - if note_index = 2^SONG_ADDR_W-1, go to DONE (no wrap);
  - otherwise note_index <= note_index+1 and go to FETCH.
- DONE: song_done = 1 and no loads are issued. Stays in DONE until new_song.
- The play input never blocks WAIT_CLEAR or WAIT_DONE. The player pauses itself via play_enable.
- rom_addr = {song_reg, note_index} at all times, including IDLE.
- A note value of 0 is a rest. It is loaded like any other note, with no special handling.

## Timing
- load_new_note is decoded from the registered state (state == LOAD) with no combinational path from any input.
- Start latency, new_song high at edge k with play = 1:
  - FETCH after edge k;
  - WAIT_ROM after edge k+1;
  - LOAD after edge k+2, so load_new_note is high between edges k+2 and k+3.
- Note-to-note latency: note_done = 1 sampled in WAIT_DONE at edge j → load_new_note high between edges j+2 and j+3.
- play low in WAIT_ROM delays LOAD. LOAD follows the first edge at which play = 1.
- Simultaneous events:
  - new_song in LOAD: the pulse in progress finishes its current cycle, then FETCH.
  - new_song in the same cycle as note_done: new_song wins and note_index = 0.
  - new_song in DONE: song_done falls after that edge.
- Asynchronous reset mid-note: all outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then new_song with song = 2, play = 1, ROM entry 0 = {6'd10, 6'd5}:
  - rom_addr = {2'd2, 0} after edge k;
  - load_new_note is a single-cycle pulse at edge k+2 → k+3 with note_to_load = 10 and duration_to_load = 5.
- Player model holds note_done = 1 for 3 cycles after load, then 0, then raises it:
  - no second load occurs during the stale-high window;
  - the second load occurs 2 edges after the rising note_done, with note_index = 1.
- Entry 3 duration = 0 → after note 2 completes, song_done = 1. No fourth load_new_note occurs, and the block stays in DONE for 100 cycles.
- play = 0 while in WAIT_ROM for 20 cycles → load_new_note stays 0. Raise play → the pulse follows 1 edge later and note_to_load matches ROM.
- ROM has all durations nonzero and SONG_ADDR_W = 3 → exactly 8 loads, then song_done = 1, with no wrap to index 0.
- new_song pulsed while in WAIT_DONE mid-song → note_index = 0 and the next load is entry 0 of the new song. Assert reset low mid-WAIT_CLEAR → all outputs are 0 before the next edge.
